mul_div_unit: RTL and testbench

//   Iterative multiply/divide unit in the execute stage, alongside the ALU. It takes
//   the same A/B operands from the register file and implements MIPS

---
 rtl/mul_div_unit.sv | 158 +++++++++++++++
 tb/tb_mul_div_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit (MULT/MULTU/DIV/DIVU) with HI/LO registers.
// Multiply is radix-2 shift-add, divide is radix-2 restoring shift-subtract; both
// work on operand magnitudes, and the signs are applied in the final FIX cycle.
//
// Handshake: start is sampled only while the unit is IDLE (busy=0). busy is high
// from the cycle after start is accepted until the edge that raises done. done
// is a one-cycle pulse; hi/lo and div_by_zero are valid in that cycle. The unit
// is IDLE again during the done cycle, so a new start may be issued then.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state;
    logic               is_div_q;
    logic               neg_res;   // product / quotient must be negated
    logic               neg_rem;   // remainder must be negated (sign of dividend)
    logic               dz_q;      // divide by zero: acc low half holds raw a
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   opb;       // multiplicand or divisor magnitude
    // Multiply: {partial sum, multiplier}. Divide: {remainder, quotient/dividend}.
    logic [2*WIDTH-1:0] acc;

    // Operand magnitudes and signs at launch (signed ops use op[0]=1).
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    // Operand conditioning for a launch in IDLE.
    always_comb begin
        a_neg = op[0] & a[WIDTH-1];
        b_neg = op[0] & b[WIDTH-1];
        a_mag = a_neg ? (~a + 1'b1) : a;
        b_mag = b_neg ? (~b + 1'b1) : b;
    end

    // One radix-2 step for each operation.
    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     shl;
    logic               ge;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        mul_next = {add_sum, acc[WIDTH-1:1]};
        shl      = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        ge       = (shl >= {1'b0, opb});
        // When ge holds the true difference is < opb, so the low WIDTH bits are exact.
        diff     = shl[WIDTH-1:0] - opb;
        div_next = {(ge ? diff : shl[WIDTH-1:0]), acc[WIDTH-2:0], ge};
    end

    // Sign fix-up of the finished magnitudes.
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quot_s, rem_s;

    always_comb begin
        prod_s = neg_res ? (~acc + 1'b1) : acc;
        quot_s = neg_res ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        rem_s  = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    end

    // Control FSM, datapath registers and HI/LO in one registered process.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            is_div_q    <= 1'b0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            dz_q        <= 1'b0;
            cnt         <= '0;
            opb         <= '0;
            acc         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div_q <= op[1];
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        cnt      <= CW'(WIDTH - 1);
                        busy     <= 1'b1;
                        if (op[1] && (b == '0)) begin
                            dz_q  <= 1'b1;
                            acc   <= {{WIDTH{1'b0}}, a};
                            opb   <= '0;
                            state <= FIX;
                        end else begin
                            dz_q  <= 1'b0;
                            acc   <= {{WIDTH{1'b0}}, a_mag};
                            opb   <= b_mag;
                            state <= CALC;
                        end
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                CALC: begin
                    acc <= is_div_q ? div_next : mul_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= FIX;
                end
                FIX: begin
                    if (dz_q) begin
                        hi          <= acc[WIDTH-1:0];
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                    end else if (is_div_q) begin
                        hi <= rem_s;
                        lo <= quot_s;
                    end else begin
                        hi <= prod_s[2*WIDTH-1:WIDTH];
                        lo <= prod_s[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit: directed and randomized operations compared
// against an arithmetic reference model, plus MTHI/MTLO, ignore and reset cases.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_pass   = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference model straight from the MIPS arithmetic rules.
    function automatic void ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                      output logic [31:0] eh, output logic [31:0] el, output logic ed);
        logic [63:0] p;
        longint sx, sy, q, r;
        ed = 1'b0;
        eh = '0;
        el = '0;
        case (o)
            2'd0: begin
                p = {32'b0, x} * {32'b0, y};
                eh = p[63:32]; el = p[31:0];
            end
            2'd1: begin
                sx = $signed(x); sy = $signed(y);
                p = 64'(sx * sy);
                eh = p[63:32]; el = p[31:0];
            end
            default: begin
                if (y == 32'd0) begin
                    eh = x; el = 32'hFFFF_FFFF; ed = 1'b1;
                end else if (o == 2'd2) begin
                    el = x / y; eh = x % y;
                end else begin
                    sx = $signed(x); sy = $signed(y);
                    q = sx / sy; r = sx % sy;
                    el = q[31:0]; eh = r[31:0];
                end
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Driver: called at a negedge; launches one op and returns at the done negedge.
    // lat counts edges after the launch edge; busy_cnt counts cycles with busy=1.
    task automatic run_op(input logic [1:0] o, input logic [31:0] oa, input logic [31:0] ob,
                          output logic [31:0] rhi, output logic [31:0] rlo, output logic rdz,
                          output int lat, output int busy_cnt);
        start = 1'b1; op = o; a = oa; b = ob;
        @(negedge clk);
        start = 1'b0;
        lat = 0; busy_cnt = 0;
        while (!done && lat < 200) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        rhi = hi; rlo = lo; rdz = div_by_zero;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
        n_checks++; if (div_by_zero !== 1'b0) $display("FAIL reset_dz got %b want 0", div_by_zero); else n_pass++;
        n_checks++; if (hi !== 32'h0) $display("FAIL reset_hi got %h want 0", hi); else n_pass++;
        n_checks++; if (lo !== 32'h0) $display("FAIL reset_lo got %h want 0", lo); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [1:0]  t_op [5] = '{2'd1, 2'd0, 2'd3, 2'd3, 2'd2};
        logic [31:0] t_a  [5] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000, 32'd100};
        logic [31:0] t_b  [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] t_hi [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'd100};
        logic [31:0] t_lo [5] = '{32'hFFFF_FFEB, 32'h0000_0001, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF};
        logic        t_dz [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int          t_lat[5] = '{33, 33, 33, 33, 1};
        logic [31:0] rh, rl;
        logic        rd;
        int          lat, bc;
        for (int i = 0; i < 5; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], rh, rl, rd, lat, bc);
            n_checks++; if (lat !== t_lat[i]) $display("FAIL dir%0d_latency got %0d want %0d", i, lat, t_lat[i]); else n_pass++;
            n_checks++; if (bc !== t_lat[i]) $display("FAIL dir%0d_busy_cycles got %0d want %0d", i, bc, t_lat[i]); else n_pass++;
            n_checks++; if (rh !== t_hi[i]) $display("FAIL dir%0d_hi got %h want %h", i, rh, t_hi[i]); else n_pass++;
            n_checks++; if (rl !== t_lo[i]) $display("FAIL dir%0d_lo got %h want %h", i, rl, t_lo[i]); else n_pass++;
            n_checks++; if (rd !== t_dz[i]) $display("FAIL dir%0d_dz got %b want %b", i, rd, t_dz[i]); else n_pass++;
            @(negedge clk);
            n_checks++; if ({done, div_by_zero, busy} !== 3'b000)
                $display("FAIL dir%0d_pulse_end got done/dz/busy=%b want 000", i, {done, div_by_zero, busy}); else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] x, y, rh, rl, eh, el;
        logic        rd, ed;
        int          lat, bc, elat;
        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom_range(0, 3));
            x = pick_operand();
            y = pick_operand();
            ref_model(o, x, y, eh, el, ed);
            elat = ed ? 1 : 33;
            run_op(o, x, y, rh, rl, rd, lat, bc);
            n_checks++; if (lat !== elat) $display("FAIL rnd%0d_latency op=%0d got %0d want %0d", i, o, lat, elat); else n_pass++;
            n_checks++; if (rh !== eh) $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got %h want %h", i, o, x, y, rh, eh); else n_pass++;
            n_checks++; if (rl !== el) $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got %h want %h", i, o, x, y, rl, el); else n_pass++;
            n_checks++; if (rd !== ed) $display("FAIL rnd%0d_dz op=%0d got %b want %b", i, o, rd, ed); else n_pass++;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_ignored_while_busy();
        logic [31:0] hi_before, lo_before;
        int          lat;
        logic        held;
        hi_before = hi; lo_before = lo;
        start = 1'b1; op = 2'd0; a = 32'd3; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        lat = 0; held = 1'b1;
        while (!done && lat < 200) begin
            if (lat == 10) begin
                start = 1'b1; op = 2'd2; a = 32'd77; b = 32'd0;
                hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0; hi_we = 1'b0;
            end
            @(negedge clk);
            lat++;
            if (!done && (hi !== hi_before || lo !== lo_before)) held = 1'b0;
        end
        start = 1'b0; hi_we = 1'b0;
        n_checks++; if (held !== 1'b1) $display("FAIL busy_hold hi/lo changed during op got 0 want 1"); else n_pass++;
        n_checks++; if (lat !== 33) $display("FAIL ign_latency got %0d want 33", lat); else n_pass++;
        n_checks++; if (hi !== 32'd0) $display("FAIL ign_hi got %h want 0", hi); else n_pass++;
        n_checks++; if (lo !== 32'd15) $display("FAIL ign_lo got %h want f", lo); else n_pass++;
        n_checks++; if (div_by_zero !== 1'b0) $display("FAIL ign_dz got %b want 0", div_by_zero); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_mthi_mtlo();
        int lat;
        hi_we = 1'b1; wdata = 32'hA5A5_0001;
        @(negedge clk);
        hi_we = 1'b0;
        n_checks++; if (hi !== 32'hA5A5_0001) $display("FAIL mthi got %h want a5a50001", hi); else n_pass++;
        lo_we = 1'b1; wdata = 32'h5A5A_0002;
        @(negedge clk);
        lo_we = 1'b0;
        n_checks++; if (lo !== 32'h5A5A_0002) $display("FAIL mtlo got %h want 5a5a0002", lo); else n_pass++;
        n_checks++; if (hi !== 32'hA5A5_0001) $display("FAIL mtlo_keeps_hi got %h want a5a50001", hi); else n_pass++;
        // start wins over a simultaneous MTLO
        start = 1'b1; op = 2'd0; a = 32'd2; b = 32'd3; lo_we = 1'b1; wdata = 32'hFFFF_0000;
        @(negedge clk);
        start = 1'b0; lo_we = 1'b0;
        n_checks++; if (lo !== 32'h5A5A_0002) $display("FAIL start_wins_lo got %h want 5a5a0002", lo); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL start_wins_busy got %b want 1", busy); else n_pass++;
        lat = 0;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        n_checks++; if (lo !== 32'd6) $display("FAIL start_wins_result got %h want 6", lo); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rh, rl;
        logic        rd;
        int          lat, bc;
        run_op(2'd0, 32'd6, 32'd7, rh, rl, rd, lat, bc);
        n_checks++; if (rl !== 32'd42) $display("FAIL b2b_first_lo got %h want 2a", rl); else n_pass++;
        run_op(2'd2, 32'd50, 32'd7, rh, rl, rd, lat, bc);
        n_checks++; if (lat !== 33) $display("FAIL b2b_second_latency got %0d want 33", lat); else n_pass++;
        n_checks++; if (rl !== 32'd7) $display("FAIL b2b_second_lo got %h want 7", rl); else n_pass++;
        n_checks++; if (rh !== 32'd1) $display("FAIL b2b_second_hi got %h want 1", rh); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_midop();
        start = 1'b1; op = 2'd1; a = 32'hFFFF_FFFB; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (hi !== 32'h0) $display("FAIL midrst_hi got %h want 0", hi); else n_pass++;
        n_checks++; if (lo !== 32'h0) $display("FAIL midrst_lo got %h want 0", lo); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        lo_we = 1'b1; wdata = 32'h0000_1234;
        @(negedge clk);
        lo_we = 1'b0;
        n_checks++; if (lo !== 32'h0000_1234) $display("FAIL midrst_mtlo got %h want 1234", lo); else n_pass++;
        repeat (40) @(negedge clk);
        n_checks++; if ({done, busy, hi} !== {2'b00, 32'h0}) $display("FAIL midrst_discarded got done/busy/hi=%b%b/%h want 00/0", done, busy, hi); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignored_while_busy();
        test_mthi_mtlo();
        test_back_to_back();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
